branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the execute-stage branch comparator.
- Resolves conditional branches for all six RV32/RV64 branch funct3 codes, with one registered result stage.
- Hosts a direct-mapped branch history table (BHT) of 2-bit saturating counters: fetch reads a prediction, execute trains it and reports mispredict plus redirect PC.
- Keeps saturating branch/mispredict statistics counters for performance monitoring.

Parameters:
- XLEN, 32, operand and PC width (32 or 64).
- BHT_ENTRIES, 16, number of BHT counters; power of 2, 2..1024.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  XLEN  fetch PC for prediction lookup.
- if_pred_taken  out  1  combinational MSB of BHT[index(if_pc)].
- ex_valid  in  1  execute-stage instruction valid.
- ex_branch  in  1  instruction is a conditional branch.
- ex_kill  in  1  squash this cycle's execute instruction.
- ex_funct3  in  3  branch condition code.
- ex_a  in  XLEN  rs1 operand.
- ex_b  in  XLEN  rs2 operand.
- ex_pc  in  XLEN  PC of the branch.
- ex_target  in  XLEN  precomputed taken target.
- ex_pred_taken  in  1  prediction carried down the pipeline.
- res_valid  out  1  registered: a branch was resolved last cycle.
- res_taken  out  1  registered branch outcome.
- res_mispredict  out  1  registered: res_taken != carried prediction.
- res_redirect_pc  out  XLEN  registered correct next PC.
- res_illegal  out  1  registered: funct3 was 010 or 011.
- stat_branches  out  CNT_W  resolved-branch count, saturating.
- stat_mispredicts  out  CNT_W  mispredict count, saturating.

Behaviour:
- index(pc) = pc[IDX_W+1:2], where IDX_W = log2(BHT_ENTRIES).
- Resolve condition: go = ex_valid & ex_branch & ~ex_kill & ~rst.
- Condition decode:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 are illegal: taken = 0.
- Result stage, 1-cycle latency:
  - When go: res_valid=1 and res_taken=taken.
  - res_redirect_pc = taken ? ex_target : ex_pc+4, truncated to XLEN (wraps at 2^XLEN).
  - res_mispredict = taken ^ ex_pred_taken.
  - res_illegal = (funct3 is 010 or 011).
  - When not go: res_valid, res_taken, res_mispredict and res_illegal all 0; res_redirect_pc holds its last value.
- Illegal funct3:
  - res_valid=1, res_taken=0, res_illegal=1; res_mispredict is still computed.
  - BHT is NOT updated; stat counters are NOT incremented.
- BHT update, legal go only, on the same edge as the result register:
  - taken: counter +1, saturating at 3.
  - not taken: counter -1, saturating at 0.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter MSB.
- Lookup and update of the same index in the same cycle: if_pred_taken returns the pre-update value (no bypass); the new value is visible the next cycle.
- Statistics (legal go only):
  - stat_branches +1.
  - stat_mispredicts +1 when mispredicted.
  - Both hold at all-ones; neither wraps.
- Reset (synchronous):
  - All BHT counters to 01.
  - All res_* outputs to 0, res_redirect_pc = 0.
  - Both stat counters to 0.
  - A branch presented during the rst cycle is dropped: no result, no update.
- ex_kill overrides ex_valid: no result, no BHT update, no statistics update.
- No backpressure; a branch may be accepted every cycle.

Decomposition:
- Package branch_pkg:
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - 2-bit counter encodings: SNT, WNT, WT, ST.
  - Counter reset value WNT.
- Sub-module bht_2bit (params ENTRIES, IDX_W):
  - One combinational read port, one synchronous update port (idx, we, taken).
  - Synchronous reset to WNT.
- Top level contains the comparator decode, result register and stat counters.

Test Plan:
- All six funct3 codes with a=32'hFFFF_FFFF, b=1 -> beq 0, bne 1, blt 1, bge 0, bltu 0, bgeu 1. Each appears one cycle after issue with res_valid=1.
- Training:
  - After reset, if_pc=0x40 -> if_pred_taken=0.
  - Two taken beq at pc 0x40 -> prediction becomes 1.
  - Three further taken -> counter stays 11.
  - One not-taken -> prediction still 1.
- Mispredict/redirect:
  - pc=0x100, target=0x80, pred=0, taken -> res_mispredict=1, redirect=0x80.
  - Same branch not-taken with pred=1 -> mispredict=1, redirect=0x104.
  - stat_mispredicts=2.
- Illegal and kill:
  - funct3=010 -> res_illegal=1, res_taken=0, BHT and stats unchanged.
  - ex_kill=1 with a valid branch -> res_valid=0, no BHT or stats change.
- Same-cycle lookup/update at index 3 -> if_pred_taken shows the old value that cycle and the new value the next cycle.
- Reset mid-stream and saturation:
  - rst asserted with a branch present -> next cycle all res_* = 0, stats = 0, BHT at WNT.
  - With CNT_W=4, 20 branches -> stat_branches = 15.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants for branch resolution: funct3 codes, 2-bit counter encodings
// and the helpers used by the comparator and the history table.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam ctr_t CTR_RST = WNT;

   // 010 and 011 are the only holes in the branch funct3 space
   function automatic logic f3_illegal(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      if (taken && c != ST) begin
         n = ctr_t'(c + 2'd1);
      end else if (!taken && c != SNT) begin
         n = ctr_t'(c - 2'd1);
      end
      return n;
   endfunction

endpackage

// File: rtl/bht_2bit.sv
// Direct-mapped table of 2-bit saturating counters, combinational read.
// Update lands on the next edge; a same-cycle read returns the old value. No backpressure.
module bht_2bit
   import branch_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             we,
   input  logic             wr_taken
);

   ctr_t tbl [ENTRIES];

   assign rd_taken = tbl[rd_idx][1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i] <= CTR_RST;
         end
      end else if (we) begin
         tbl[wr_idx] <= ctr_next(tbl[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with BHT prediction/training and saturating stats.
// One registered result stage; no backpressure, a branch may be accepted every cycle.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_pred_taken,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic             ex_kill,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_a,
   input  logic [XLEN-1:0]  ex_b,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_pred_taken,
   output logic             res_valid,
   output logic             res_taken,
   output logic             res_mispredict,
   output logic [XLEN-1:0]  res_redirect_pc,
   output logic             res_illegal,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic go;
   logic illegal;
   logic train;
   logic taken;
   logic mispredict;
   logic unused_pc_bits;

   assign go         = ex_valid & ex_branch & ~ex_kill & ~rst;
   assign illegal    = f3_illegal(ex_funct3);
   assign train      = go & ~illegal;
   assign mispredict = taken ^ ex_pred_taken;

   // Only the word-aligned index bits of the fetch PC address the table
   assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

   always_comb begin
      taken = 1'b0;
      case (ex_funct3)
         F3_BEQ:  taken = (ex_a == ex_b);
         F3_BNE:  taken = (ex_a != ex_b);
         F3_BLT:  taken = ($signed(ex_a) <  $signed(ex_b));
         F3_BGE:  taken = ($signed(ex_a) >= $signed(ex_b));
         F3_BLTU: taken = (ex_a <  ex_b);
         F3_BGEU: taken = (ex_a >= ex_b);
         default: taken = 1'b0;
      endcase
   end

   bht_2bit #(
      .ENTRIES (BHT_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (if_pc[IDX_W+1:2]),
      .rd_taken (if_pred_taken),
      .wr_idx   (ex_pc[IDX_W+1:2]),
      .we       (train),
      .wr_taken (taken)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid       <= 1'b0;
         res_taken       <= 1'b0;
         res_mispredict  <= 1'b0;
         res_illegal     <= 1'b0;
         res_redirect_pc <= '0;
      end else begin
         res_valid      <= go;
         res_taken      <= go & taken;
         res_mispredict <= go & mispredict;
         res_illegal    <= go & illegal;
         // Redirect PC is sticky when nothing resolves
         if (go) begin
            res_redirect_pc <= taken ? ex_target : ex_pc + XLEN'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (train) begin
         if (stat_branches != '1) begin
            stat_branches <= stat_branches + CNT_W'(1);
         end
         if (mispredict && stat_mispredicts != '1) begin
            stat_mispredicts <= stat_mispredicts + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench with a behavioural model of outcome, BHT and statistics.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken, if_pred_taken_s;
   logic        ex_valid, ex_branch, ex_kill, ex_pred_taken;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_a, ex_b, ex_pc, ex_target;
   logic        res_valid, res_taken, res_mispredict, res_illegal;
   logic [31:0] res_redirect_pc;
   logic [15:0] stat_branches, stat_mispredicts;
   logic        s_valid, s_taken, s_mispredict, s_illegal;
   logic [31:0] s_redirect_pc;
   logic [3:0]  s_branches, s_mispredicts;

   int n_cmp = 0;
   int n_err = 0;

   // Model state
   int          m_bht [16];
   bit          e_valid, e_taken, e_mis, e_ill;
   logic [31:0] e_redir;
   int          e_br, e_mp, e_br4, e_mp4;

   always #5 clk = ~clk;

   branch_resolve_unit dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_kill(ex_kill), .ex_funct3(ex_funct3),
      .ex_a(ex_a), .ex_b(ex_b), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
      .res_mispredict(res_mispredict), .res_redirect_pc(res_redirect_pc),
      .res_illegal(res_illegal), .stat_branches(stat_branches),
      .stat_mispredicts(stat_mispredicts)
   );

   branch_resolve_unit #(.CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken_s),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_kill(ex_kill), .ex_funct3(ex_funct3),
      .ex_a(ex_a), .ex_b(ex_b), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .res_valid(s_valid), .res_taken(s_taken),
      .res_mispredict(s_mispredict), .res_redirect_pc(s_redirect_pc),
      .res_illegal(s_illegal), .stat_branches(s_branches),
      .stat_mispredicts(s_mispredicts)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int sa = a;
      int sb = b;
      longint unsigned ua = a;
      longint unsigned ub = b;
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return ua < ub;
         3'd7: return ua >= ub;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat_inc(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   task automatic model_reset();
      foreach (m_bht[i]) m_bht[i] = 1;
      e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0; e_redir = 32'h0;
      e_br = 0; e_mp = 0; e_br4 = 0; e_mp4 = 0;
   endtask

   task automatic drive(input bit v, input bit br, input bit kl, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit pred, input logic [31:0] ipc);
      ex_valid = v; ex_branch = br; ex_kill = kl; ex_funct3 = f; ex_a = a; ex_b = b;
      ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; if_pc = ipc;
   endtask

   // Check the lookup, advance one clock, advance the model, check results
   task automatic cycle();
      bit go, ill, tk;
      int wi;
      #1;
      chk("if_pred", if_pred_taken, m_bht[(if_pc >> 2) % 16] >= 2);
      go = ex_valid && ex_branch && !ex_kill && !rst;
      ill = (ex_funct3 == 3'd2) || (ex_funct3 == 3'd3);
      tk = ref_taken(ex_funct3, ex_a, ex_b);
      wi = (ex_pc >> 2) % 16;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         e_valid = go;
         e_taken = go && tk;
         e_mis = go && (tk != ex_pred_taken);
         e_ill = go && ill;
         if (go) e_redir = tk ? ex_target : ex_pc + 32'd4;
         if (go && !ill) begin
            m_bht[wi] = tk ? (m_bht[wi] == 3 ? 3 : m_bht[wi] + 1) : (m_bht[wi] == 0 ? 0 : m_bht[wi] - 1);
            e_br = sat_inc(e_br, 65535);
            e_br4 = sat_inc(e_br4, 15);
            if (tk != ex_pred_taken) begin
               e_mp = sat_inc(e_mp, 65535);
               e_mp4 = sat_inc(e_mp4, 15);
            end
         end
      end
      #1;
      chk("res_valid", res_valid, e_valid);
      chk("res_taken", res_taken, e_taken);
      chk("res_mispredict", res_mispredict, e_mis);
      chk("res_illegal", res_illegal, e_ill);
      chk("res_redirect_pc", res_redirect_pc, e_redir);
      chk("stat_branches", stat_branches, e_br);
      chk("stat_mispredicts", stat_mispredicts, e_mp);
      chk("stat_branches_w4", s_branches, e_br4);
      chk("stat_mispredicts_w4", s_mispredicts, e_mp4);
   endtask

   initial begin
      logic [5:0] f3_exp;
      logic [2:0] f3_list [6];
      logic [31:0] ra, rb;
      f3_list = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      f3_exp  = 6'b100110;  // bgeu bltu bge blt bne beq, LSB first
      model_reset();

      // Reset with a branch present: must be dropped
      rst = 1'b1;
      drive(1, 1, 0, 3'd0, 32'h5, 32'h5, 32'h40, 32'h80, 0, 32'h40);
      cycle();
      cycle();
      rst = 1'b0;
      chk("reset_valid", res_valid, 1'b0);
      chk("reset_stats", stat_branches, 16'd0);

      // All six condition codes, a=-1 b=1
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 0, f3_list[i], 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h300, 0, 32'h0);
         cycle();
         chk("f3_table_valid", res_valid, 1'b1);
         chk("f3_table_taken", res_taken, f3_exp[i]);
      end

      // Training at 0x40 from reset state
      rst = 1'b1; drive(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h40); cycle(); rst = 1'b0;
      chk("train_init", if_pred_taken, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 0, 3'd0, 32'h7, 32'h7, 32'h40, 32'h90, 1, 32'h40);
         cycle();
         if (i == 1) chk("train_two_taken", if_pred_taken, 1'b1);
      end
      drive(1, 1, 0, 3'd0, 32'h7, 32'h8, 32'h40, 32'h90, 1, 32'h40);
      cycle();
      chk("train_one_nt", if_pred_taken, 1'b1);

      // Mispredict and redirect
      rst = 1'b1; drive(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0); cycle(); rst = 1'b0;
      drive(1, 1, 0, 3'd0, 32'h3, 32'h3, 32'h100, 32'h80, 0, 32'h100);
      cycle();
      chk("mp_taken_redirect", res_redirect_pc, 32'h80);
      chk("mp_taken_flag", res_mispredict, 1'b1);
      drive(1, 1, 0, 3'd0, 32'h3, 32'h4, 32'h100, 32'h80, 1, 32'h100);
      cycle();
      chk("mp_nt_redirect", res_redirect_pc, 32'h104);
      chk("mp_count", stat_mispredicts, 16'd2);

      // Illegal funct3 and kill
      drive(1, 1, 0, 3'd2, 32'h3, 32'h3, 32'h100, 32'h80, 1, 32'h100);
      cycle();
      chk("illegal_flag", res_illegal, 1'b1);
      chk("illegal_stats", stat_branches, 16'd2);
      drive(1, 1, 1, 3'd0, 32'h3, 32'h3, 32'h100, 32'h80, 0, 32'h100);
      cycle();
      chk("kill_valid", res_valid, 1'b0);

      // Same-cycle lookup and update at index 3
      drive(1, 1, 0, 3'd0, 32'h1, 32'h1, 32'hC, 32'h20, 0, 32'hC);
      #1 chk("bypass_old", if_pred_taken, 1'b0);
      cycle();
      drive(0, 0, 0, 3'd0, 0, 0, 32'hC, 0, 0, 32'hC);
      #1 chk("bypass_new", if_pred_taken, 1'b1);
      cycle();

      // Randomized traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + $urandom_range(0, 3) : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : (($urandom_range(0, 2) == 0) ? ~ra : $urandom);
         rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
               3'($urandom), ra, rb, {$urandom_range(0, 31), 2'b00} + 32'hFFFF_FF80,
               $urandom, $urandom_range(0, 1), {$urandom_range(0, 31), 2'b00});
         cycle();
      end
      rst = 1'b0;

      // Twenty legal branches saturate the 4-bit counter
      for (int n = 0; n < 20; n++) begin
         drive(1, 1, 0, 3'd1, 32'h1, 32'h2, 32'h10, 32'h50, 0, 32'h10);
         cycle();
      end
      chk("sat_w4", s_branches, 4'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
